// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle for the external SRAM controller.
// The MEM stage is the master; the controller is the slave.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Initiator-side controller for the 16-bit asynchronous SRAM.
// Each 32-bit word access becomes two sequential half-word accesses
// (low half, then high half), each held for WAIT_CYCLES clocks.
//
// state | meaning
// IDLE  | no access in flight, waiting for wr_en/rd_en
// LOW   | accessing {word,0}, low 16 bits of the word
// HIGH  | accessing {word,1}, high 16 bits of the word
// DONE  | access finished, ready high for this one cycle
module sram_controller #(
    parameter int ADDR_W       = 18,
    parameter int DQ_W         = 16,
    parameter int BASE_ADDRESS = 1024,
    parameter int WAIT_CYCLES  = 5
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [DQ_W-1:0]   SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    counter;
    logic                op_wr;
    logic [ADDR_W-2:0]   word_q;
    logic [ADDR_W-2:0]   word_in;
    logic [2*DQ_W-1:0]   wdata_q;
    logic [2*DQ_W-1:0]   read_data_q;
    logic [31:0]         addr_off;
    logic                addr_unused;
    logic                req;
    logic                phase_end;
    logic                rdy;
    logic                we_active;
    logic [DQ_W-1:0]     dq_out;

    assign req       = bus.wr_en | bus.rd_en;
    assign phase_end = (counter == CNT_LAST);

    // Offset from the SRAM window; the byte-lane bits and anything above
    // the word range are dropped, so low addresses simply wrap.
    assign addr_off    = bus.address - 32'(BASE_ADDRESS);
    assign word_in     = addr_off[ADDR_W:2];
    assign addr_unused = ^{addr_off[31:ADDR_W+1], addr_off[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and ready decode.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        case (state)
            IDLE: begin
                rdy = !req;
                if (req) state_nxt = LOW;
            end
            LOW:  if (phase_end) state_nxt = HIGH;
            HIGH: if (phase_end) state_nxt = DONE;
            DONE: begin
                rdy       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, phase counter, SRAM address and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter     <= '0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            SRAM_ADDR   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        counter   <= '0;
                        op_wr     <= bus.wr_en;
                        word_q    <= word_in;
                        wdata_q   <= bus.write_data;
                        SRAM_ADDR <= {word_in, 1'b0};
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        counter   <= '0;
                        SRAM_ADDR <= {word_q, 1'b1};
                        if (!op_wr) read_data_q[DQ_W-1:0] <= SRAM_DQ;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        counter <= '0;
                        if (!op_wr) read_data_q[2*DQ_W-1:DQ_W] <= SRAM_DQ;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The bus is driven only while the write strobe is low, so the SRAM
    // output and our driver can never fight.
    assign we_active = op_wr && (state == LOW || state == HIGH);
    assign dq_out    = (state == HIGH) ? wdata_q[2*DQ_W-1:DQ_W] : wdata_q[DQ_W-1:0];
    assign SRAM_DQ   = we_active ? dq_out : {DQ_W{1'bz}};
    assign SRAM_WE_N = !we_active;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.ready     = rdy;
    assign bus.read_data = read_data_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator-side controller for the external 16-bit asynchronous SRAM.
- Converts 32-bit word read/write requests from the pipeline MEM stage into two sequential 16-bit SRAM accesses: low half first, then high half.
- Holds `ready` low while an access is in flight; the hazard/freeze logic stalls the pipeline on `~ready`.
- Owns the SRAM_DQ tri-state: drives it only during writes and releases it otherwise.

Parameters:
- ADDR_W, 18, SRAM word-address width (matches `LEN_SRAM_ADDRESS_BUS`).
- DQ_W, 16, SRAM data-bus width (matches `LEN_SRAM_DATA_BUS`).
- BASE_ADDRESS, 1024, byte address that maps to SRAM location 0.
- WAIT_CYCLES, 5, number of clk cycles each half-access is held; must be ≥2 to cover the 30 ns SRAM output delay at 50 MHz.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  word write request; level, held until ready.
- rd_en  input  1  word read request; level, held until ready.
- address  input  32  byte address from the ALU.
- write_data  input  32  word to store.
- read_data  output  32  last completed read word (registered).
- ready  output  1  high when no access is in flight or the current one completes this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  active-low write strobe.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0 (always enabled).

Behaviour:
- Reset (rst high at posedge) takes precedence over everything, including an access in progress:
  - state=IDLE, counter=0, read_data=0.
  - SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=high-Z.
  - A partially done access is abandoned; no completion is signalled.
- Address map:
  - word = (address − BASE_ADDRESS) >> 2, truncated to ADDR_W−1 bits.
  - Low half at SRAM_ADDR = {word,0}; high half at SRAM_ADDR = {word,1}.
  - address[1:0] is ignored.
  - Addresses below BASE_ADDRESS wrap modulo 2^ADDR_W. No error is flagged.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en|rd_en at posedge → LOW, counter=0, and latch op (write when wr_en=1; wr_en beats rd_en when both are high), word and write_data. Otherwise stay.
  - LOW: counter increments each cycle. At the posedge where counter==WAIT_CYCLES−1 → HIGH, counter=0. On a read, read_data[15:0] is captured from SRAM_DQ at that same edge.
  - HIGH: same as LOW, but the exit goes to DONE and a read captures read_data[31:16].
  - DONE: one cycle, then unconditionally → IDLE.
- Latency: acceptance edge to DONE is 2×WAIT_CYCLES edges; ready=1 for exactly that DONE cycle.
- ready is combinational: (state==IDLE && !wr_en && !rd_en) || state==DONE.
  - ready drops in the same cycle a request appears in IDLE.
- SRAM drive:
  - SRAM_ADDR is registered: {word,0} throughout LOW and {word,1} throughout HIGH. It holds its last value in IDLE/DONE.
  - On writes, SRAM_WE_N=0 and SRAM_DQ is driven with write_data[15:0] during LOW and write_data[31:16] during HIGH; the SRAM rewrites identical data on every cycle of the phase, which is harmless.
  - In IDLE, DONE and on reads, SRAM_WE_N=1 and SRAM_DQ=high-Z. The controller never drives DQ while WE_N=1.
- Request still asserted in the cycle after DONE: treated as a new request in IDLE. The requester must deassert or advance on ready.
- Request inputs changing mid-access: ignored, because the op, word and data were latched at acceptance.
- read_data only changes at read capture edges. A write leaves it unchanged.

Test Plan:
- Write 0xDEADBEEF at address 1024, then read 1024 (WAIT_CYCLES=5) → SRAM_ADDR is 0 for 5 cycles then 1 for 5 cycles, SRAM_WE_N=0 across those 10 cycles, memory[0]=0xBEEF and memory[1]=0xDEAD; the read returns read_data=0xDEADBEEF.
- Latency: rd_en asserted in IDLE → ready=0 in the same cycle, ready=1 exactly in the 11th cycle (DONE), back in IDLE the next cycle; with rd_en held, ready drops again.
- Address mapping: write 0x12345678 at 1028 and 0x9ABCDEF0 at 1030 → both land at SRAM 2/3 (low bits ignored), and the final read of 1028 returns 0x9ABCDEF0; address 0 → word 0x1FF00 (wrap).
- wr_en=rd_en=1 at address 1032 with write_data=0xCAFEF00D → a write is performed, read_data is unchanged, and a follow-up read returns 0xCAFEF00D.
- rst pulsed in cycle 3 of LOW during a write → the next cycle shows IDLE, SRAM_WE_N=1, DQ high-Z, ready=1 (no request), read_data=0; the first half may be written but no DONE occurs.
- Bus contention check: a monitor asserts that SRAM_DQ is never driven by the controller while SRAM_WE_N=1, across 200 random rd/wr requests with a scoreboard comparing read data.
